i2c_arbiter: RTL and testbench

Round-robin arbiter that shares the single `i2c` write master between several configuration requesters, such as the HDMI config queue and an audio codec config queue. Each requester presents a 3-byte write (7-bit address plus two data bytes) with a level request. The arbiter picks one requester, drives the master's command inputs and start pulse, and tracks the master's `busy` signal. It then returns a one-cycle `done` or `err` pulse to the winner. It sits in the `clk_250kHz` domain between the queues and the `i2c` instance.

---
 rtl/i2c_arb_pkg.sv | 28 ++
 rtl/i2c_arbiter_rr_select.sv | 34 +++
 rtl/i2c_arbiter.sv | 121 ++++++++++++
 tb/tb_i2c_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared widths, state encoding and command bundle
// for the round-robin arbiter in front of the i2c write master.
package i2c_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    XFER,
    DONE,
    HOLDOFF
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_0;
    logic [DATA_W-1:0] data_1;
  } i2c_cmd_t;

  // Width of the busy-rise timeout counter; never narrower than 1 bit.
  function automatic int cnt_width(input int busy_wait);
    return (busy_wait < 2) ? 1 : $clog2(busy_wait);
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr_select.sv
// rr_select: combinational round-robin picker, searching upward
// from last+1 and wrapping modulo N_REQ.
module rr_select
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ < 2) ? 1 : $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   j;

  // First set request after the previous winner wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(last) + k) % N_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one i2c write master between N_REQ
// requesters, round-robin, with busy-rise timeout reporting.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ     = 2,
  parameter int BUSY_WAIT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [ADDR_W*N_REQ-1:0]  req_address,
  input  logic [DATA_W*N_REQ-1:0]  req_data_0,
  input  logic [DATA_W*N_REQ-1:0]  req_data_1,
  output logic [N_REQ-1:0]         grant,
  output logic [N_REQ-1:0]         done,
  output logic [N_REQ-1:0]         err,
  output logic                     i2c_start,
  output logic [ADDR_W-1:0]        cmd_address,
  output logic [DATA_W-1:0]        data_0,
  output logic [DATA_W-1:0]        data_1,
  input  logic                     i2c_busy
);

  localparam int IDX_W = (N_REQ < 2) ? 1 : $clog2(N_REQ);
  localparam int CW    = cnt_width(BUSY_WAIT);

  arb_state_t       state;
  logic [IDX_W-1:0] last;
  logic [CW-1:0]    cnt;

  logic [N_REQ-1:0] sel_gnt;
  logic [IDX_W-1:0] sel_idx;
  i2c_cmd_t         sel_cmd;

  rr_select #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req  (req),
    .last (last),
    .gnt  (sel_gnt),
    .idx  (sel_idx)
  );

  // Pick the winner's fields out of the packed request buses.
  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_gnt[i]) begin
        sel_cmd.address = req_address[ADDR_W*i +: ADDR_W];
        sel_cmd.data_0  = req_data_0[DATA_W*i +: DATA_W];
        sel_cmd.data_1  = req_data_1[DATA_W*i +: DATA_W];
      end
    end
  end

  // Arbiter FSM; every output is registered on the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= IDX_W'(N_REQ - 1);
      cnt         <= '0;
      grant       <= '0;
      done        <= '0;
      err         <= '0;
      i2c_start   <= 1'b0;
      cmd_address <= '0;
      data_0      <= '0;
      data_1      <= '0;
    end else begin
      i2c_start <= 1'b0;
      done      <= '0;
      err       <= '0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant       <= sel_gnt;
            last        <= sel_idx;
            cmd_address <= sel_cmd.address;
            data_0      <= sel_cmd.data_0;
            data_1      <= sel_cmd.data_1;
            i2c_start   <= 1'b1;
            state       <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (i2c_busy) begin
            state <= XFER;
          end else if (cnt == CW'(BUSY_WAIT - 1)) begin
            err   <= grant;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (!i2c_busy) begin
            done  <= grant;
            state <= DONE;
          end
        end
        DONE: begin
          grant <= '0;
          state <= HOLDOFF;
        end
        HOLDOFF: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: directed vectors, corner sequences and a
// randomized run checked against a transaction-level model.
module tb_i2c_arbiter;

  localparam int NR  = 3;
  localparam int BW  = 8;
  localparam int LIM = 200;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req;
  logic [7*NR-1:0] req_address;
  logic [8*NR-1:0] req_data_0;
  logic [8*NR-1:0] req_data_1;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   done;
  logic [NR-1:0]   err;
  logic            i2c_start;
  logic [6:0]      cmd_address;
  logic [7:0]      data_0;
  logic [7:0]      data_1;
  logic            i2c_busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int m_len   = 0;
  bit m_abort = 1'b0;

  typedef struct {
    int         id;
    logic [6:0] a;
    logic [7:0] d0;
    logic [7:0] d1;
    int         blen;
    int         lat;
    bit         is_err;
  } vec_t;

  vec_t vt[5];

  i2c_arbiter #(
    .N_REQ     (NR),
    .BUSY_WAIT (BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_address (req_address),
    .req_data_0  (req_data_0),
    .req_data_1  (req_data_1),
    .grant       (grant),
    .done        (done),
    .err         (err),
    .i2c_start   (i2c_start),
    .cmd_address (cmd_address),
    .data_0      (data_0),
    .data_1      (data_1),
    .i2c_busy    (i2c_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Master model: busy rises when the start pulse is seen and
  // stays high for m_len cycles; m_len == 0 means it never rises.
  initial begin
    i2c_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (i2c_start && m_len > 0 && !m_abort) begin
        i2c_busy = 1'b1;
        for (int n = 0; n < m_len && !m_abort; n++)
          @(negedge clk);
        i2c_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] a,
                         input logic [7:0] d0,
                         input logic [7:0] d1);
    req_address[7*i +: 7] = a;
    req_data_0[8*i +: 8]  = d0;
    req_data_1[8*i +: 8]  = d1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_start(input int lim, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if (i2c_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_end(input int lim,
                          output logic [NR-1:0] dm,
                          output logic [NR-1:0] em,
                          output int tc);
    dm = '0;
    em = '0;
    tc = -1;
    for (int n = 0; n < lim; n++) begin
      @(negedge clk);
      if ((done | err) != '0) begin
        dm = done;
        em = err;
        tc = cyc;
        break;
      end
    end
  endtask

  task automatic idle_gap();
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  function automatic int next_len();
    if ($urandom_range(0, 4) == 0) return 0;
    return int'($urandom_range(2, 12));
  endfunction

  task automatic run_one(input vec_t v);
    bit ok;
    int t0;
    int tc;
    logic [NR-1:0] dm;
    logic [NR-1:0] em;
    set_req(v.id, v.a, v.d0, v.d1);
    m_len = v.blen;
    t0 = cyc;
    req[v.id] = 1'b1;
    wait_start(4, ok);
    check("vec_start", 32'(ok), 32'd1);
    check("vec_start_lat", 32'(cyc - t0), 32'd1);
    check("vec_grant", 32'(grant), 32'(1 << v.id));
    check("vec_addr", 32'(cmd_address), 32'(v.a));
    check("vec_d0", 32'(data_0), 32'(v.d0));
    check("vec_d1", 32'(data_1), 32'(v.d1));
    wait_end(60, dm, em, tc);
    check("vec_done", 32'(dm), v.is_err ? 32'd0 : 32'(1 << v.id));
    check("vec_err", 32'(em), v.is_err ? 32'(1 << v.id) : 32'd0);
    check("vec_lat", 32'(tc - t0), 32'(v.lat));
    req[v.id] = 1'b0;
    idle_gap();
    check("vec_idle_grant", 32'(grant), 32'd0);
  endtask

  initial begin
    bit ok;
    int t0;
    int ts;
    int tprev;
    int tc;
    int w;
    int j;
    bit found;
    logic [NR-1:0] dm;
    logic [NR-1:0] em;
    int model_last;
    bit act;
    int aw;
    bit a_err;
    int a_end;
    int gap[NR];
    int wcnt[NR];

    vt[0] = '{0, 7'h39, 8'h41, 8'h10, 20, 22, 1'b0};
    vt[1] = '{1, 7'h5A, 8'hA5, 8'h3C, 2, 4, 1'b0};
    vt[2] = '{0, 7'h7F, 8'hFF, 8'h00, 0, 10, 1'b1};
    vt[3] = '{2, 7'h00, 8'h12, 8'h34, 0, 10, 1'b1};
    vt[4] = '{2, 7'h11, 8'h22, 8'h33, 5, 7, 1'b0};

    req         = '0;
    req_address = '0;
    req_data_0  = '0;
    req_data_1  = '0;
    rst         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_start", 32'(i2c_start), 32'd0);
    check("rst_addr", 32'(cmd_address), 32'd0);
    check("rst_d0", 32'(data_0), 32'd0);
    check("rst_d1", 32'(data_1), 32'd0);

    for (int i = 0; i < 5; i++) run_one(vt[i]);

    do_reset();
    set_req(0, 7'h21, 8'h01, 8'h02);
    set_req(1, 7'h42, 8'h03, 8'h04);
    m_len = 6;
    req   = 3'b011;
    tprev = 0;
    for (int n = 0; n < 4; n++) begin
      wait_start(40, ok);
      check("sim_start", 32'(ok), 32'd1);
      ts = cyc;
      w  = n % 2;
      check("sim_grant", 32'(grant), 32'(1 << w));
      check("sim_addr", 32'(cmd_address), (w == 1) ? 32'h42 : 32'h21);
      if (n > 0) check("sim_space", 32'(ts - tprev), 32'd10);
      tprev = ts;
      wait_end(40, dm, em, tc);
      check("sim_done", 32'(dm), 32'(1 << w));
      check("sim_err", 32'(em), 32'd0);
    end
    req = '0;
    idle_gap();

    do_reset();
    set_req(0, 7'h12, 8'h34, 8'h56);
    set_req(1, 7'h65, 8'h43, 8'h21);
    m_len = 30;
    req   = 3'b011;
    wait_start(4, ok);
    check("rx_start", 32'(ok), 32'd1);
    check("rx_grant0", 32'(grant), 32'd1);
    repeat (5) @(negedge clk);
    check("rx_mid_grant", 32'(grant), 32'd1);
    m_abort = 1'b1;
    m_len   = 3;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rx_grant", 32'(grant), 32'd0);
    check("rx_done", 32'(done), 32'd0);
    check("rx_err", 32'(err), 32'd0);
    check("rx_start0", 32'(i2c_start), 32'd0);
    check("rx_addr", 32'(cmd_address), 32'd0);
    check("rx_d0", 32'(data_0), 32'd0);
    check("rx_d1", 32'(data_1), 32'd0);
    @(posedge clk);
    #1;
    m_abort = 1'b0;
    wait_start(4, ok);
    check("rx_restart", 32'(ok), 32'd1);
    check("rx_first", 32'(grant), 32'd1);
    check("rx_first_addr", 32'(cmd_address), 32'h12);
    wait_end(20, dm, em, tc);
    check("rx_final_done", 32'(dm), 32'd1);
    req = '0;
    idle_gap();

    set_req(1, 7'h55, 8'hAA, 8'h0F);
    m_len = 12;
    t0 = cyc;
    req[1] = 1'b1;
    wait_start(4, ok);
    check("drop_start", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    req[1] = 1'b0;
    set_req(1, 7'h00, 8'h00, 8'h00);
    dm = '0;
    em = '0;
    tc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      check("drop_addr", 32'(cmd_address), 32'h55);
      check("drop_d0", 32'(data_0), 32'hAA);
      check("drop_d1", 32'(data_1), 32'h0F);
      if ((done | err) != '0) begin
        dm = done;
        em = err;
        tc = cyc;
        break;
      end
    end
    check("drop_done", 32'(dm), 32'd2);
    check("drop_err", 32'(em), 32'd0);
    check("drop_lat", 32'(tc - t0), 32'd14);
    idle_gap();

    do_reset();
    model_last = NR - 1;
    act   = 1'b0;
    aw    = 0;
    a_err = 1'b0;
    a_end = 0;
    m_len = next_len();
    for (int i = 0; i < NR; i++) begin
      gap[i]  = int'($urandom_range(0, 6));
      wcnt[i] = 0;
    end
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (i2c_start) begin
        check("rnd_start_busy", 32'(act), 32'd0);
        found = 1'b0;
        w = 0;
        for (int k = 1; k <= NR; k++) begin
          j = (model_last + k) % NR;
          if (!found && req[j]) begin
            found = 1'b1;
            w = j;
          end
        end
        check("rnd_start_req", 32'(found), 32'd1);
        check("rnd_grant", 32'(grant), 32'(1 << w));
        check("rnd_addr", 32'(cmd_address), 32'(req_address[7*w +: 7]));
        check("rnd_d0", 32'(data_0), 32'(req_data_0[8*w +: 8]));
        check("rnd_d1", 32'(data_1), 32'(req_data_1[8*w +: 8]));
        act   = 1'b1;
        aw    = w;
        a_err = (m_len == 0);
        a_end = cyc + (a_err ? 1 + BW : m_len + 1);
        model_last = w;
      end
      if (act) check("rnd_hold_grant", 32'(grant), 32'(1 << aw));
      if (act && cyc == a_end) begin
        check("rnd_done", 32'(done), a_err ? 32'd0 : 32'(1 << aw));
        check("rnd_err", 32'(err), a_err ? 32'(1 << aw) : 32'd0);
        act = 1'b0;
        req[aw] = 1'b0;
        check("rnd_wait_bound", 32'(wcnt[aw] <= LIM), 32'd1);
        wcnt[aw] = 0;
        gap[aw]  = int'($urandom_range(1, 6));
        m_len    = next_len();
      end else if ((done | err) != '0) begin
        check("rnd_spurious", 32'(done | err), 32'd0);
      end
      for (int i = 0; i < NR; i++) begin
        if (req[i]) begin
          wcnt[i]++;
        end else if (gap[i] == 0) begin
          set_req(i, 7'($urandom), 8'($urandom), 8'($urandom));
          req[i] = 1'b1;
        end else begin
          gap[i]--;
        end
      end
    end
    for (int i = 0; i < NR; i++)
      check("rnd_final_wait", 32'(wcnt[i] <= LIM), 32'd1);
    req = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
